// File: rtl/sifive_tl_a_channel_arbiter.sv
// sifive_tl_a_channel_arbiter
//   Shares one TileLink A channel between N_REQ requesters and one slave port.
//   - Round-robin arbitration. The search starts after the last winner.
//   - A multi-beat Put/Atomic keeps the channel until its last beat.
//   - A stalled offer (out_valid & ~out_ready) keeps its grant until it fires.
//   - The payload mux is combinational. Only the arbitration state is registered.
// Ports
//   clock, reset                     sync active-high reset
//   in_valid/in_ready [N_REQ]        per-requester handshake
//   in_opcode/size/source/address/mask/data   packed, requester i at [W*i +: W]
//   out_valid/out_ready              slave handshake
//   out_opcode..out_data             muxed beat of the granted requester
//   out_grant [N_REQ]                one-hot selection, 0 when none
//   out_last                         current beat ends its message

// Per-requester beat count, decoded from the first beat's opcode and size.
module sifive_tl_a_beats #(
    parameter int SIZE_W = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 14
) (
    input  logic [2:0]        opcode,
    input  logic [SIZE_W-1:0] size,
    output logic [CNT_W-1:0]  beats
);
    localparam int LG_BYTES = $clog2(DATA_W/8);

    // The opcodes 0..3 carry data. Each of them has opcode[2] clear.
    always_comb begin
        beats = CNT_W'(1);
        if (!opcode[2] && size > SIZE_W'(LG_BYTES))
            beats = CNT_W'(1) << (size - SIZE_W'(LG_BYTES));
    end
endmodule

module sifive_tl_a_channel_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int SIZE_W = 4,
    parameter int SRC_W  = 7
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          in_valid,
    output logic [N_REQ-1:0]          in_ready,
    input  logic [3*N_REQ-1:0]        in_opcode,
    input  logic [SIZE_W*N_REQ-1:0]   in_size,
    input  logic [SRC_W*N_REQ-1:0]    in_source,
    input  logic [ADDR_W*N_REQ-1:0]   in_address,
    input  logic [DATA_W/8*N_REQ-1:0] in_mask,
    input  logic [DATA_W*N_REQ-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_opcode,
    output logic [SIZE_W-1:0]         out_size,
    output logic [SRC_W-1:0]          out_source,
    output logic [ADDR_W-1:0]         out_address,
    output logic [DATA_W/8-1:0]       out_mask,
    output logic [DATA_W-1:0]         out_data,
    output logic [N_REQ-1:0]          out_grant,
    output logic                      out_last
);
    localparam int MASK_W   = DATA_W/8;
    localparam int PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LG_BYTES = $clog2(MASK_W);
    localparam int MAX_SIZE = (1 << SIZE_W) - 1;
    localparam int MAX_LG   = (MAX_SIZE > LG_BYTES) ? MAX_SIZE - LG_BYTES : 0;
    localparam int CNT_W    = MAX_LG + 1;

    typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

    state_t                      state, state_nxt;
    logic [PTR_W-1:0]            ptr, ptr_nxt;
    logic [N_REQ-1:0]            lock, lock_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;

    logic [N_REQ-1:0][CNT_W-1:0] beats;
    logic [N_REQ-1:0]            rr_grant;
    logic [CNT_W-1:0]            sel_beats;
    logic [PTR_W-1:0]            sel_idx;
    logic                        fire;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        sifive_tl_a_beats #(.SIZE_W(SIZE_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_beats (
            .opcode (in_opcode[3*i +: 3]),
            .size   (in_size[SIZE_W*i +: SIZE_W]),
            .beats  (beats[i])
        );
    end

    // Round-robin pick. The search starts at ptr+1 and wraps modulo N_REQ.
    always_comb begin
        int  idx;
        logic found;
        rr_grant = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && in_valid[idx]) begin
                rr_grant[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // While a beat is stalled or a burst is running, the lock drives the grant.
    // This keeps the selection fixed even if other requesters become valid.
    always_comb begin
        out_grant = '0;
        if (!reset)
            out_grant = (state == IDLE) ? rr_grant : lock;
    end

    always_comb begin
        out_opcode  = '0;
        out_size    = '0;
        out_source  = '0;
        out_address = '0;
        out_mask    = '0;
        out_data    = '0;
        sel_beats   = '0;
        sel_idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (out_grant[i]) begin
                out_opcode  = in_opcode[3*i +: 3];
                out_size    = in_size[SIZE_W*i +: SIZE_W];
                out_source  = in_source[SRC_W*i +: SRC_W];
                out_address = in_address[ADDR_W*i +: ADDR_W];
                out_mask    = in_mask[MASK_W*i +: MASK_W];
                out_data    = in_data[DATA_W*i +: DATA_W];
                sel_beats   = beats[i];
                sel_idx     = PTR_W'(i);
            end
        end
    end

    assign out_valid = |(in_valid & out_grant);
    assign in_ready  = out_grant & {N_REQ{out_ready}};
    assign fire      = out_valid & out_ready;
    assign out_last  = (state == BURST) ? (cnt == CNT_W'(1)) : (sel_beats == CNT_W'(1));

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock;
        cnt_nxt   = cnt;
        case (state)
            IDLE, HOLD: begin
                if (fire) begin
                    ptr_nxt = sel_idx;
                    if (sel_beats > CNT_W'(1)) begin
                        state_nxt = BURST;
                        lock_nxt  = out_grant;
                        cnt_nxt   = sel_beats - CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        lock_nxt  = '0;
                        cnt_nxt   = '0;
                    end
                end else if (out_valid) begin
                    state_nxt = HOLD;
                    lock_nxt  = out_grant;
                end
            end
            BURST: begin
                // If the locked requester pauses, out_valid drops and nothing advances.
                if (fire) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = IDLE;
                        lock_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                lock_nxt  = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= PTR_W'(N_REQ - 1);
            lock  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            lock  <= lock_nxt;
            cnt   <= cnt_nxt;
        end
    end
endmodule
